// File: rtl/n2t_pc.sv
// Hack-style program counter with an optional return-address stack for call/return.
// The stack is built only when N2T_PC_STACK_EN is defined; otherwise push/pop are ignored.
module n2t_pc #(
   parameter int STACK_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [15:0] in,
   input  logic        clr,
   input  logic        load,
   input  logic        inc,
   input  logic        push,
   input  logic        pop,
   output logic [15:0] out,
   output logic        stack_full,
   output logic        stack_empty,
   output logic        stack_err
);

`ifdef N2T_PC_STACK_EN
   // sp counts stored entries, so it needs one extra bit to represent "full".
   localparam int SPW = $clog2(STACK_DEPTH) + 1;

   logic [15:0]    stack_mem [STACK_DEPTH];
   logic [SPW-1:0] sp;
   logic [SPW-1:0] sp_m1;
   logic           err_q;
   logic           full;
   logic           empty;
   logic           do_push;

   assign sp_m1   = sp - SPW'(1);
   assign full    = (sp == SPW'(STACK_DEPTH));
   assign empty   = (sp == '0);
   assign do_push = rst_n && en && !clr && !pop && push && !full;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out   <= 16'h0000;
         sp    <= '0;
         err_q <= 1'b0;
      end else if (en) begin
         if (clr) begin
            out   <= 16'h0000;
            sp    <= '0;
            err_q <= 1'b0;
         end else if (pop) begin
            if (!empty) begin
               out <= stack_mem[sp_m1[SPW-2:0]];
               sp  <= sp_m1;
            end else begin
               err_q <= 1'b1;
            end
         end else if (push) begin
            if (!full) begin
               out <= in;
               sp  <= sp + SPW'(1);
            end else begin
               err_q <= 1'b1;
            end
         end else if (load) begin
            out <= in;
         end else if (inc) begin
            out <= out + 16'd1;
         end
      end
   end

   // Entries carry no reset value; they are only read back below a valid sp.
   always_ff @(posedge clk) begin
      if (do_push) begin
         stack_mem[sp[SPW-2:0]] <= out + 16'd1;
      end
   end

   assign stack_full  = full;
   assign stack_empty = empty;
   assign stack_err   = err_q;
`else
   logic unused_stack_ctl;

   assign unused_stack_ctl = ^{push, pop};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out <= 16'h0000;
      end else if (en) begin
         if (clr) begin
            out <= 16'h0000;
         end else if (load) begin
            out <= in;
         end else if (inc) begin
            out <= out + 16'd1;
         end
      end
   end

   assign stack_full  = 1'b0;
   assign stack_empty = 1'b1;
   assign stack_err   = 1'b0;
`endif

endmodule

// File: tb/tb_n2t_pc.sv
// Scoreboarded bench for n2t_pc: directed call/return scenarios plus random traffic,
// checked against a queue-based return-stack model (follows N2T_PC_STACK_EN).
module tb_n2t_pc;

   localparam int DEPTH = 8;
   localparam int W     = 19;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [15:0] in;
   logic        clr;
   logic        load;
   logic        inc;
   logic        push;
   logic        pop;
   logic [15:0] out;
   logic        stack_full;
   logic        stack_empty;
   logic        stack_err;

   n2t_pc #(.STACK_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .in          (in),
      .clr         (clr),
      .load        (load),
      .inc         (inc),
      .push        (push),
      .pop         (pop),
      .out         (out),
      .stack_full  (stack_full),
      .stack_empty (stack_empty),
      .stack_err   (stack_err)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [15:0]   m_pc;
   logic [15:0]   m_stack[$];
   logic          m_err;
   logic [W-1:0]  exp_q[$];
   int            checks = 0;
   int            errors = 0;
   int            cyc    = 0;

   function automatic logic [W-1:0] model_expect();
      logic f;
      logic e;
`ifdef N2T_PC_STACK_EN
      f = (m_stack.size() == DEPTH);
      e = (m_stack.size() == 0);
      return {m_pc, f, e, m_err};
`else
      f = 1'b0;
      e = 1'b1;
      return {m_pc, f, e, 1'b0};
`endif
   endfunction

   task automatic model_step(input logic r, input logic e, input logic c, input logic l,
                             input logic i, input logic pu, input logic po, input logic [15:0] d);
      if (!r) begin
         m_pc = 16'h0000;
         m_stack.delete();
         m_err = 1'b0;
      end else if (e) begin
         if (c) begin
            m_pc = 16'h0000;
            m_stack.delete();
            m_err = 1'b0;
         end
`ifdef N2T_PC_STACK_EN
         else if (po) begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else m_err = 1'b1;
         end else if (pu) begin
            if (m_stack.size() < DEPTH) begin
               m_stack.push_back(16'((int'(m_pc) + 1) % 65536));
               m_pc = d;
            end else begin
               m_err = 1'b1;
            end
         end
`endif
         else if (l) m_pc = d;
         else if (i) m_pc = 16'((int'(m_pc) + 1) % 65536);
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive(input logic r, input logic e, input logic c, input logic l,
                        input logic i, input logic pu, input logic po, input logic [15:0] d);
      @(negedge clk);
      rst_n = r; en = e; clr = c; load = l; inc = i; push = pu; pop = po; in = d;
      model_step(r, e, c, l, i, pu, po, d);
      exp_q.push_back(model_expect());
   endtask

   task automatic op_reset();                  drive(0, 1, 0, 0, 0, 0, 0, 16'h0);  endtask
   task automatic op_inc();                    drive(1, 1, 0, 0, 1, 0, 0, 16'h0);  endtask
   task automatic op_load(input logic [15:0] d); drive(1, 1, 0, 1, 0, 0, 0, d);    endtask
   task automatic op_push(input logic [15:0] d); drive(1, 1, 0, 0, 0, 1, 0, d);    endtask
   task automatic op_pop();                    drive(1, 1, 0, 0, 0, 0, 1, 16'h0);  endtask

   // ---------------- monitor / scoreboard ----------------
   always @(posedge clk) begin
      logic [W-1:0] exp_v;
      logic [W-1:0] act_v;
      #1;
      if (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         act_v = {out, stack_full, stack_empty, stack_err};
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL cyc%0d out/full/empty/err got %h/%b/%b/%b exp %h/%b/%b/%b", cyc,
                     act_v[18:3], act_v[2], act_v[1], act_v[0],
                     exp_v[18:3], exp_v[2], exp_v[1], exp_v[0]);
         end
      end
      cyc++;
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0; en = 1'b0; in = 16'h0; clr = 1'b0;
      load = 1'b0; inc = 1'b0; push = 1'b0; pop = 1'b0;
      m_pc = 16'h0; m_err = 1'b0;

      // reset overrides en=0 and other inputs
      drive(0, 0, 0, 1, 1, 1, 1, 16'h1234);
      op_reset();
      // count from zero
      repeat (3) op_inc();
      // wrap
      op_load(16'hFFFF);
      op_inc();
      // call / return
      op_load(16'h0010);
      op_push(16'h0200);
      op_pop();
      // overflow then underflow
      for (int k = 0; k < DEPTH + 1; k++) op_push(16'h1000 + 16'(k));
      for (int k = 0; k < DEPTH + 1; k++) op_pop();
      op_inc();
      // clr wins over everything else
      op_push(16'h0400);
      drive(1, 1, 1, 1, 1, 1, 1, 16'h5555);
      // stall holds state
      op_load(16'h0077);
      drive(1, 0, 0, 0, 1, 0, 0, 16'h0);
      drive(1, 0, 1, 1, 0, 1, 1, 16'h9999);
      // push without load when the stack may be absent
      op_push(16'h0300);
      // reset between push and pop discards saved addresses
      op_push(16'h0500);
      op_reset();
      op_pop();
      drive(1, 1, 1, 0, 0, 0, 0, 16'h0);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         logic r;
         logic e;
         r = ($urandom_range(0, 99) != 0);
         e = ($urandom_range(0, 9) != 0);
         drive(r, e,
               ($urandom_range(0, 29) == 0),
               ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 1) == 1),
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 3) == 0),
               16'($urandom_range(0, 65535)));
      end

      @(negedge clk);
      rst_n = 1'b1; en = 1'b0;
      for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain pending got %0d exp 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
